// File: rtl/fifo_ctrl.sv
// fifo_ctrl: control unit for the board FIFO (DEPTH = 2**ADDR_W entries of DATA_W bits).
// It accepts one-cycle push/pop pulses and arbitrates between them, alternating when both
// are requested at once. It sequences writes and synchronous reads into an external memory
// and keeps the pointers, the occupancy, the full/empty flags and the sticky error flags.
//
// Ports:
//   clk_200H   in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   wr_req     in   push pulse
//   rd_req     in   pop pulse
//   sw_data    in   push data, sampled with an accepted wr_req
//   clr_err    in   clears ovf_err / udf_err
//   mem_we     out  memory write enable (high only in the WRITE state)
//   mem_waddr  out  memory write address (write pointer)
//   mem_wdata  out  memory write data (held push data)
//   mem_raddr  out  memory read address (read pointer)
//   mem_rdata  in   memory read data, valid one cycle after mem_raddr
//   rd_data_q  out  last popped entry
//   rd_valid   out  one-cycle pulse when rd_data_q updates
//   count      out  occupancy, 0..DEPTH
//   full       out  count == DEPTH
//   empty      out  count == 0
//   ovf_err    out  sticky: push attempted while full
//   udf_err    out  sticky: pop attempted while empty
module fifo_ctrl #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk_200H,
    input  logic              reset,
    input  logic              wr_req,
    input  logic              rd_req,
    input  logic [DATA_W-1:0] sw_data,
    input  logic              clr_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] rd_data_q,
    output logic              rd_valid,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              ovf_err,
    output logic              udf_err
);

    localparam int unsigned       DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    typedef enum logic [1:0] {StIdle, StWrite, StRdAddr, StRdCap} state_e;
    typedef enum logic {OpRead, OpWrite} op_e;

    state_e              state;
    op_e                 last_op;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   rd_ptr;
    logic                wr_pend;
    logic                rd_pend;
    logic [DATA_W-1:0]   wdata_hold;

    logic                w_eff;
    logic                r_eff;
    logic                grant_w;
    logic                grant_r;

    // Effective requests combine fresh pulses with latched ones; on a tie the requester that
    // did not go last wins.
    always_comb begin
        w_eff   = wr_req | wr_pend;
        r_eff   = rd_req | rd_pend;
        grant_w = w_eff && (!r_eff || (last_op == OpRead));
        grant_r = r_eff && !grant_w;
    end

    assign full      = (count == CNT_FULL);
    assign empty     = (count == '0);
    assign mem_we    = (state == StWrite);
    assign mem_waddr = wr_ptr;
    assign mem_raddr = rd_ptr;
    assign mem_wdata = wdata_hold;

    always_ff @(posedge clk_200H or posedge reset) begin
        if (reset) begin
            state      <= StIdle;
            last_op    <= OpRead;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            wr_pend    <= 1'b0;
            rd_pend    <= 1'b0;
            wdata_hold <= '0;
            rd_data_q  <= '0;
            rd_valid   <= 1'b0;
            ovf_err    <= 1'b0;
            udf_err    <= 1'b0;
        end else begin
            rd_valid <= 1'b0;

            // Clear first so that an error event later in this block wins on the same edge.
            if (clr_err) begin
                ovf_err <= 1'b0;
                udf_err <= 1'b0;
            end

            // A write already waiting keeps its own data; later pushes are ignored.
            if (wr_req && !wr_pend) begin
                wdata_hold <= sw_data;
            end

            // Requests arriving while busy wait in their single pending slot.
            if (state != StIdle) begin
                if (wr_req) wr_pend <= 1'b1;
                if (rd_req) rd_pend <= 1'b1;
            end

            unique case (state)
                StIdle: begin
                    if (grant_w) begin
                        wr_pend <= 1'b0;
                        if (r_eff) rd_pend <= 1'b1;
                        if (full) begin
                            ovf_err <= 1'b1;
                        end else begin
                            state <= StWrite;
                        end
                    end else if (grant_r) begin
                        rd_pend <= 1'b0;
                        if (w_eff) wr_pend <= 1'b1;
                        if (empty) begin
                            udf_err <= 1'b1;
                        end else begin
                            state <= StRdAddr;
                        end
                    end
                end
                StWrite: begin
                    wr_ptr  <= wr_ptr + PTR_ONE;
                    count   <= count + CNT_ONE;
                    last_op <= OpWrite;
                    state   <= StIdle;
                end
                StRdAddr: begin
                    // Memory samples mem_raddr on this edge; data is available in StRdCap.
                    state <= StRdCap;
                end
                StRdCap: begin
                    rd_data_q <= mem_rdata;
                    rd_ptr    <= rd_ptr + PTR_ONE;
                    count     <= count - CNT_ONE;
                    last_op   <= OpRead;
                    rd_valid  <= 1'b1;
                    state     <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: behavioural synchronous-read memory, a reference FIFO
// queue and a read scoreboard checked whenever rd_valid pulses.
module tb_fifo_ctrl;

    logic       clk_200H;
    logic       reset;
    logic       wr_req;
    logic       rd_req;
    logic [7:0] sw_data;
    logic       clr_err;
    logic       mem_we;
    logic [2:0] mem_waddr;
    logic [7:0] mem_wdata;
    logic [2:0] mem_raddr;
    logic [7:0] mem_rdata;
    logic [7:0] rd_data_q;
    logic       rd_valid;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       ovf_err;
    logic       udf_err;

    fifo_ctrl #(
        .DATA_W(8),
        .ADDR_W(3)
    ) dut (
        .clk_200H (clk_200H),
        .reset    (reset),
        .wr_req   (wr_req),
        .rd_req   (rd_req),
        .sw_data  (sw_data),
        .clr_err  (clr_err),
        .mem_we   (mem_we),
        .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata),
        .mem_raddr(mem_raddr),
        .mem_rdata(mem_rdata),
        .rd_data_q(rd_data_q),
        .rd_valid (rd_valid),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .ovf_err  (ovf_err),
        .udf_err  (udf_err)
    );

    initial clk_200H = 1'b0;
    always #5 clk_200H = ~clk_200H;

    // Storage array: registered read, one cycle after the address.
    logic [7:0] mem [8];
    always @(posedge clk_200H) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
        mem_rdata <= mem[mem_raddr];
    end

    typedef enum {OpPush, OpPop, OpClr} op_t;
    typedef struct {
        op_t        op;
        logic [7:0] data;
        int         exp_count;
        logic       exp_full;
        logic       exp_empty;
        logic       exp_ovf;
        logic       exp_udf;
    } vec_t;

    vec_t       vecs [20];
    logic [7:0] model [$];
    logic [7:0] exp_q [$];
    int         wptr;
    int         rptr;
    int         n_cmp;
    int         n_err;
    logic [7:0] last_wdata;
    logic [2:0] last_waddr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Advance one clock, sample 1 time unit after the edge and run the read scoreboard.
    task automatic tick();
        @(posedge clk_200H);
        #1;
        if (mem_we) begin
            last_wdata = mem_wdata;
            last_waddr = mem_waddr;
        end
        if (exp_q.size() == 0) begin
            check("no_spurious_rd_valid", 32'(rd_valid), 32'd0);
        end else if (rd_valid) begin
            check("rd_data", 32'(rd_data_q), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_count"}, 32'(count), 32'd0);
        check({tag, "_empty"}, 32'(empty), 32'd1);
        check({tag, "_full"}, 32'(full), 32'd0);
        check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
        check({tag, "_rd_data"}, 32'(rd_data_q), 32'd0);
        check({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
        check({tag, "_waddr"}, 32'(mem_waddr), 32'd0);
        check({tag, "_raddr"}, 32'(mem_raddr), 32'd0);
        check({tag, "_ovf"}, 32'(ovf_err), 32'd0);
        check({tag, "_udf"}, 32'(udf_err), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model.delete();
        wptr = 0;
        rptr = 0;
        tick();
        tick();
        check_reset_vals("reset");
        reset = 1'b0;
        tick();
    endtask

    task automatic do_push(input logic [7:0] d);
        wr_req  = 1'b1;
        sw_data = d;
        if (model.size() == 8) begin
            tick();
            check("ovf_no_write", 32'(mem_we), 32'd0);
            check("ovf_set", 32'(ovf_err), 32'd1);
            wr_req  = 1'b0;
            sw_data = 8'($urandom);
            tick();
        end else begin
            tick();
            check("push_we", 32'(mem_we), 32'd1);
            check("push_waddr", 32'(mem_waddr), 32'(wptr));
            check("push_wdata", 32'(mem_wdata), 32'(d));
            wr_req  = 1'b0;
            sw_data = 8'($urandom);
            model.push_back(d);
            wptr = (wptr + 1) % 8;
            tick();
            check("push_we_width", 32'(mem_we), 32'd0);
        end
    endtask

    task automatic do_pop();
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        if (model.size() == 0) begin
            check("udf_set", 32'(udf_err), 32'd1);
            tick();
            tick();
            tick();
        end else begin
            check("pop_raddr", 32'(mem_raddr), 32'(rptr));
            exp_q.push_back(model.pop_front());
            rptr = (rptr + 1) % 8;
            tick();
            check("rd_valid_early", 32'(rd_valid), 32'd0);
            tick();
            check("rd_valid_lat", 32'(rd_valid), 32'd1);
            tick();
            check("rd_valid_width", 32'(rd_valid), 32'd0);
        end
    endtask

    task automatic do_clr();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 12 && exp_q.size() != 0; i++) tick();
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        wptr = 0;
        rptr = 0;
        last_wdata = '0;
        last_waddr = '0;
        reset = 1'b1;
        wr_req = 1'b0;
        rd_req = 1'b0;
        sw_data = '0;
        clr_err = 1'b0;

        // Table: fill to full, overflow, clear, drain to empty, underflow, clear.
        for (int i = 0; i < 8; i++) begin
            vecs[i] = '{OpPush, 8'(8'h11 * (i + 1)), i + 1, (i == 7), 1'b0, 1'b0, 1'b0};
        end
        vecs[8] = '{OpPush, 8'h99, 8, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[9] = '{OpClr, 8'h00, 8, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            vecs[10 + i] = '{OpPop, 8'h00, 7 - i, 1'b0, (i == 7), 1'b0, 1'b0};
        end
        vecs[18] = '{OpPop, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[19] = '{OpClr, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b0};

        // Reset state, then a single push of 0xA5.
        do_reset();
        do_push(8'hA5);
        check("a5_count", 32'(count), 32'd1);
        check("a5_empty", 32'(empty), 32'd0);

        do_reset();
        for (int i = 0; i < 20; i++) begin
            unique case (vecs[i].op)
                OpPush: do_push(vecs[i].data);
                OpPop:  do_pop();
                OpClr:  do_clr();
            endcase
            check($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
            check($sformatf("v%0d_full", i), 32'(full), 32'(vecs[i].exp_full));
            check($sformatf("v%0d_empty", i), 32'(empty), 32'(vecs[i].exp_empty));
            check($sformatf("v%0d_ovf", i), 32'(ovf_err), 32'(vecs[i].exp_ovf));
            check($sformatf("v%0d_udf", i), 32'(udf_err), 32'(vecs[i].exp_udf));
            check($sformatf("v%0d_waddr", i), 32'(mem_waddr), 32'(wptr));
            check($sformatf("v%0d_raddr", i), 32'(mem_raddr), 32'(rptr));
        end

        // Simultaneous push and pop with count=2 after a read: write wins, read follows.
        do_push(8'hAA);
        do_push(8'hBB);
        do_push(8'hCC);
        do_pop();
        wr_req  = 1'b1;
        rd_req  = 1'b1;
        sw_data = 8'hDD;
        tick();
        check("arb_write_first", 32'(mem_we), 32'd1);
        check("arb_waddr", 32'(mem_waddr), 32'(wptr));
        exp_q.push_back(model.pop_front());
        rptr = (rptr + 1) % 8;
        model.push_back(8'hDD);
        wptr = (wptr + 1) % 8;
        wr_req  = 1'b0;
        rd_req  = 1'b0;
        sw_data = 8'h00;
        drain("arb_read_served");
        tick();
        check("arb_count", 32'(count), 32'(model.size()));

        // Pop during a write, then push 0x3C during the read: both queue up and run in order.
        wr_req  = 1'b1;
        sw_data = 8'hEE;
        tick();
        model.push_back(8'hEE);
        wptr = (wptr + 1) % 8;
        wr_req = 1'b0;
        rd_req = 1'b1;
        tick();
        exp_q.push_back(model.pop_front());
        rptr = (rptr + 1) % 8;
        rd_req = 1'b0;
        tick();
        wr_req  = 1'b1;
        sw_data = 8'h3C;
        tick();
        wr_req  = 1'b0;
        sw_data = 8'hFF;
        last_wdata = 8'h00;
        for (int i = 0; i < 12 && last_wdata != 8'h3C; i++) tick();
        check("pend_read_done", 32'(exp_q.size()), 32'd0);
        check("pend_wdata", 32'(last_wdata), 32'h3C);
        check("pend_waddr", 32'(last_waddr), 32'(wptr));
        model.push_back(8'h3C);
        wptr = (wptr + 1) % 8;
        tick();
        check("pend_count", 32'(count), 32'(model.size()));
        do_pop();
        do_pop();
        do_pop();
        check("pend_empty", 32'(empty), 32'd1);

        // Reset asserted while in RD_CAP with count=3.
        do_push(8'h01);
        do_push(8'h02);
        do_push(8'h03);
        check("pre_rst_count", 32'(count), 32'd3);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        tick();
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("async_rst");
        model.delete();
        wptr = 0;
        rptr = 0;
        tick();
        tick();
        check("rst_hold_count", 32'(count), 32'd0);
        reset = 1'b0;
        tick();
        tick();
        check("post_rst_count", 32'(count), 32'd0);

        // Normal operation after reset.
        do_push(8'h5A);
        do_pop();
        check("post_rst_empty", 32'(empty), 32'd1);

        check("final_drain", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
